irq_priority_encoder: RTL and testbench

- Registered 8-to-3 priority encoder with request latching and a valid/ack handshake. It is the encoding counterpart to the team's active-low one-hot decoders.
- Collects active-low request/select lines into sticky pending bits. Presents the highest-index unmasked pending request as a binary code and holds it stable until acknowledged.
- Sits between peripheral active-low strobes and the CPU interrupt/vector logic.

---
 rtl/irq_priority_encoder_if.sv | 29 ++
 rtl/irq_priority_encoder.sv | 96 +++++++++
 tb/tb_irq_priority_encoder.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_priority_encoder_if.sv
// Request/handshake bundle for irq_priority_encoder: the master side drives
// requests, mask, enable and ack; the slave side returns valid/code/pending.
interface irq_priority_encoder_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         g;
  logic [N-1:0] req_n;
  logic [N-1:0] mask;
  logic         ack;
  logic         valid;
  logic [W-1:0] code;
  logic         gs_n;
  logic [N-1:0] pending;
  logic [1:0]   state_dbg;

  // Handshake: code is stable while valid=1; a cycle with valid=1 and ack=1
  // at a rising edge transfers it, and ack while valid=0 is ignored.
  modport master (
    output g, req_n, mask, ack,
    input  valid, code, gs_n, pending, state_dbg
  );

  modport slave (
    input  g, req_n, mask, ack,
    output valid, code, gs_n, pending, state_dbg
  );
endinterface

// File: rtl/irq_priority_encoder.sv
// Registered N-to-log2(N) priority encoder with sticky pending bits and a
// valid/ack handshake. Define IRQ_EDGE_EN for falling-edge request capture.
module irq_priority_encoder #(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  irq_priority_encoder_if.slave bus
);
  localparam int W = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] code_q, code_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] cand;
  logic [W-1:0] pick;

`ifdef IRQ_EDGE_EN
  logic [N-1:0] hist_q;

  // History follows req_n every edge, even while g blocks latching, so a fall
  // that happens while disabled is not seen later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '1;
    else        hist_q <= bus.req_n;
  end

  assign set_vec = hist_q & ~bus.req_n & {N{~bus.g}};
`else
  assign set_vec = ~bus.req_n & {N{~bus.g}};
`endif

  always_comb begin
    clr_vec = '0;
    if (state_q == PRESENT && bus.ack) clr_vec[code_q] = 1'b1;
  end

  // Set wins over clear, so a still-active level request survives its ack.
  assign pending_d = (pending_q & ~clr_vec) | set_vec;
  assign cand      = pending_q & ~bus.mask;

  always_comb begin
    pick = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) pick = W'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (cand != '0) begin
          code_d  = pick;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (bus.ack) state_d = GAP;
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      code_q    <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      pending_q <= pending_d;
    end
  end

  assign bus.valid     = (state_q == PRESENT);
  assign bus.gs_n      = ~bus.valid;
  assign bus.code      = code_q;
  assign bus.pending   = pending_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_irq_priority_encoder.sv
// Bench for irq_priority_encoder: directed scenarios followed by random traffic,
// all checked every cycle against a behavioural model.
module tb_irq_priority_encoder;
  localparam int N = 8;
  localparam int W = $clog2(N);

  logic clk;
  logic rst_n;

  irq_priority_encoder_if #(.N(N)) ifc();

  irq_priority_encoder #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending set of sources, a presented/gap phase and the presented index.
  bit [N-1:0]    m_pending;
  bit [N-1:0]    m_hist;
  bit            m_valid;
  bit            m_gap;
  int            m_code;
  logic [W-1:0]  exp_q[$];

  function automatic int highest(input bit [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i] && r < 0) r = i;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_pending = '0;
    m_hist    = '1;
    m_valid   = 1'b0;
    m_gap     = 1'b0;
    m_code    = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit [N-1:0] nxt;
    bit [N-1:0] cand;
    nxt = m_pending;
    if (m_valid && ifc.ack) nxt[m_code] = 1'b0;
    for (int i = 0; i < N; i++) begin
`ifdef IRQ_EDGE_EN
      if (!ifc.g && !ifc.req_n[i] && m_hist[i]) nxt[i] = 1'b1;
`else
      if (!ifc.g && !ifc.req_n[i]) nxt[i] = 1'b1;
`endif
    end
    m_hist = ifc.req_n;
    cand = m_pending & ~ifc.mask;
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_valid) begin
      if (ifc.ack) begin
        m_valid = 1'b0;
        m_gap   = 1'b1;
      end
    end else if (cand != '0) begin
      m_code  = highest(cand);
      m_valid = 1'b1;
      exp_q.push_back(W'(m_code));
    end
    m_pending = nxt;
  endtask

  task automatic compare_all();
    check("valid",   ifc.valid,   m_valid);
    check("gs_n",    ifc.gs_n,    !m_valid);
    check("code",    ifc.code,    m_code);
    check("pending", ifc.pending, m_pending);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit g, input bit [N-1:0] req_n, input bit [N-1:0] mask, input bit ack);
    ifc.g     = g;
    ifc.req_n = req_n;
    ifc.mask  = mask;
    ifc.ack   = ack;
  endtask

  // One clock: scoreboard on accepted transfers, model step, compare at negedge.
  task automatic cycle();
    if (ifc.valid && ifc.ack) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else                   check("sb_code", ifc.code, exp_q.pop_front());
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    model_reset();
    #12;
    check("rst_valid",   ifc.valid,   0);
    check("rst_gs_n",    ifc.gs_n,    1);
    check("rst_code",    ifc.code,    0);
    check("rst_pending", ifc.pending, 0);
    @(negedge clk);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    rst_n = 1'b1;
    cycles(5);
    check("idle_valid", ifc.valid, 0);

    // Single request on bit 3
    drive(1'b0, 8'hF7, 8'h00, 1'b0);
    cycle();
    check("single_pend", ifc.pending, 8'h08);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycle();
    check("single_valid", ifc.valid, 1);
    check("single_code",  ifc.code,  3);
    drive(1'b0, 8'hFF, 8'h00, 1'b1);
    cycle();
    check("single_ackv", ifc.valid,   0);
    check("single_ackp", ifc.pending, 0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycles(3);
    check("single_quiet", ifc.valid, 0);

    // Priority and freeze
    drive(1'b0, 8'hDD, 8'h00, 1'b0);
    cycle();
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycle();
    check("prio_code5", ifc.code, 5);
    drive(1'b0, 8'h7F, 8'h00, 1'b0);
    cycle();
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycle();
    check("freeze_code5", ifc.code, 5);
    drive(1'b0, 8'hFF, 8'h00, 1'b1);
    cycle();
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycles(2);
    check("prio_code7", ifc.code, 7);
    check("prio_valid7", ifc.valid, 1);
    drive(1'b0, 8'hFF, 8'h00, 1'b1);
    cycle();
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycles(2);
    check("prio_code1", ifc.code, 1);
    drive(1'b0, 8'hFF, 8'h00, 1'b1);
    cycle();
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycles(3);

    // Masking and enable
    drive(1'b0, 8'h7B, 8'h80, 1'b0);
    cycle();
    drive(1'b0, 8'hFF, 8'h80, 1'b0);
    cycle();
    check("mask_code2", ifc.code, 2);
    check("mask_pend7", ifc.pending[7], 1);
    drive(1'b0, 8'hFF, 8'h00, 1'b1);
    cycle();
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycles(2);
    check("unmask_code7", ifc.code, 7);
    drive(1'b0, 8'hFF, 8'h00, 1'b1);
    cycle();
    drive(1'b1, 8'hEF, 8'h00, 1'b0);
    cycles(2);
    check("g_block_pend4", ifc.pending[4], 0);
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycles(2);

    // Set/clear collision with a held request on bit 6
    drive(1'b0, 8'hBF, 8'h00, 1'b0);
    cycles(2);
    check("coll_code6", ifc.code, 6);
    drive(1'b0, 8'hBF, 8'h00, 1'b1);
    cycle();
`ifndef IRQ_EDGE_EN
    check("coll_pend6", ifc.pending[6], 1);
`endif
    drive(1'b0, 8'hBF, 8'h00, 1'b0);
    cycles(2);
`ifndef IRQ_EDGE_EN
    check("coll_revalid", ifc.valid, 1);
    check("coll_recode",  ifc.code,  6);
`endif
    drive(1'b0, 8'hFF, 8'h00, 1'b1);
    cycle();
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycles(3);

    // Async reset while presenting code 5
    drive(1'b0, 8'hDF, 8'h00, 1'b0);
    cycle();
    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycle();
    check("pre_rst_code5", ifc.code, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid",   ifc.valid,   0);
    check("async_pending", ifc.pending, 0);
    check("async_gs_n",    ifc.gs_n,    1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    // Random traffic
    for (int t = 0; t < 600; t++) begin
      bit [N-1:0] rq;
      bit [N-1:0] mk;
      rq = '1;
      if ($urandom_range(0, 3) == 0) rq[$urandom_range(0, N - 1)] = 1'b0;
      if ($urandom_range(0, 15) == 0) rq = N'($urandom);
      mk = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      drive($urandom_range(0, 7) == 0, rq, mk, $urandom_range(0, 1) == 1);
      cycle();
    end

    drive(1'b0, 8'hFF, 8'h00, 1'b0);
    cycles(2);
    check("sb_left", exp_q.size() <= 1, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
